// File: rtl/sampler_pkg.sv
// Shared constants and helpers for the sample unpacker.
// Default widths plus a clog2 used to size the fill level.
package sampler_pkg;

    localparam int DEF_WORD_W   = 16;
    localparam int DEF_SAMPLE_W = 3;
    localparam int DEF_COUNT_W  = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_reverse.sv
// Combinational bit-order reversal of a WIDTH-bit vector.
// Used to flip words and samples for MSB-first packing.
module bit_reverse #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign dout[i] = din[WIDTH-1-i];
    end

endmodule

// File: rtl/sample_unpacker.sv
// Unpacks SAMPLE_W-bit samples from a stream of WORD_W-bit FIFO words.
// Bits pack contiguously across words; output is a registered valid/ready stage.
module sample_unpacker
    import sampler_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter bit MSB_FIRST = 1'b0,
    parameter int COUNT_W   = DEF_COUNT_W
) (
    input  logic                clk_sample,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                packet_empty,
    input  logic [WORD_W-1:0]   packet_data,
    output logic                packet_read,
    input  logic                sample_ready,
    output logic                sample_valid,
    output logic [SAMPLE_W-1:0] sample_data,
    output logic [COUNT_W-1:0]  total_sample_count,
    output logic [COUNT_W-1:0]  underrun_count
);

    localparam int BUF_W = WORD_W + SAMPLE_W - 1;
    localparam int LVL_W = clog2(BUF_W + 1);
    localparam logic [LVL_W-1:0] SAMPLE_LVL = LVL_W'(SAMPLE_W);
    localparam logic [LVL_W-1:0] WORD_LVL   = LVL_W'(WORD_W);

    // Oldest bit sits at buffer[0]; bits above lvl are always zero.
    logic [BUF_W-1:0]    buffer;
    logic [LVL_W-1:0]    lvl;
    logic                started;

    logic                load;
    logic                accept;
    logic [LVL_W-1:0]    lvl_after;
    logic [LVL_W-1:0]    lvl_next;
    logic [BUF_W-1:0]    buf_after;
    logic [BUF_W-1:0]    buf_next;
    logic [WORD_W-1:0]   word_rev;
    logic [WORD_W-1:0]   word_in;
    logic [SAMPLE_W-1:0] samp_rev;
    logic [SAMPLE_W-1:0] sample_next;

    bit_reverse #(.WIDTH(WORD_W)) u_word_rev (
        .din  (packet_data),
        .dout (word_rev)
    );

    bit_reverse #(.WIDTH(SAMPLE_W)) u_samp_rev (
        .din  (buffer[SAMPLE_W-1:0]),
        .dout (samp_rev)
    );

    // Next-state of the bit buffer: extract, then append the head word above what remains.
    always_comb begin
        word_in     = MSB_FIRST ? word_rev : packet_data;
        sample_next = MSB_FIRST ? samp_rev : buffer[SAMPLE_W-1:0];
        accept      = sample_valid && sample_ready;
        load        = (lvl >= SAMPLE_LVL) && (!sample_valid || sample_ready);
        lvl_after   = load ? (lvl - SAMPLE_LVL) : lvl;
        buf_after   = load ? (buffer >> SAMPLE_W) : buffer;
        packet_read = reset_n && !packet_empty && !clear
                      && (lvl_after < SAMPLE_LVL);
        buf_next    = buf_after;
        lvl_next    = lvl_after;
        if (packet_read) begin
            buf_next = buf_after | (BUF_W'(word_in) << lvl_after);
            lvl_next = lvl_after + WORD_LVL;
        end
    end

    // Buffer, fill level and registered output stage; clear flushes everything here.
    always_ff @(posedge clk_sample or negedge reset_n) begin
        if (!reset_n) begin
            buffer       <= '0;
            lvl          <= '0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
        end else if (clear) begin
            buffer       <= '0;
            lvl          <= '0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
        end else begin
            buffer <= buf_next;
            lvl    <= lvl_next;
            if (load) begin
                sample_data  <= sample_next;
                sample_valid <= 1'b1;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

    // Debug counters survive clear; only the stream-started flag is dropped by it.
    always_ff @(posedge clk_sample or negedge reset_n) begin
        if (!reset_n) begin
            total_sample_count <= '0;
            underrun_count     <= '0;
            started            <= 1'b0;
        end else begin
            if (accept) begin
                total_sample_count <= total_sample_count + COUNT_W'(1);
            end
            if (started && sample_ready && !sample_valid) begin
                underrun_count <= underrun_count + COUNT_W'(1);
            end
            if (clear) begin
                started <= 1'b0;
            end else if (accept) begin
                started <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sample_unpacker.sv
// Scoreboard bench: three unpacker configurations fed from small FIFO models.
// Expected samples are hand-derived and queued; a negedge monitor pops and compares.
module tb_sample_unpacker;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic [2:0]  empty;
    logic [2:0]  prd;
    logic [2:0]  rdy;
    logic [2:0]  sv;
    logic [15:0] pdata [3];
    logic [2:0]  sd0;
    logic [3:0]  sd1;
    logic [15:0] sd2;
    logic [31:0] tot [3];
    logic [31:0] und [3];

    logic [15:0] mem [3][32];
    logic [4:0]  wr [3] = '{5'd0, 5'd0, 5'd0};
    logic [4:0]  rd [3] = '{5'd0, 5'd0, 5'd0};

    logic [15:0] exp0 [$];
    logic [15:0] exp1 [$];
    logic [15:0] exp2 [$];

    int nvec = 0;
    int nbad = 0;
    int run0 = 0;
    int maxrun = 0;
    logic       prev_stall = 1'b0;
    logic [2:0] prev_data = 3'd0;

    sample_unpacker #(.WORD_W(16), .SAMPLE_W(3), .MSB_FIRST(1'b0), .COUNT_W(32)) dut0 (
        .clk_sample(clk), .reset_n(reset_n), .clear(clear),
        .packet_empty(empty[0]), .packet_data(pdata[0]), .packet_read(prd[0]),
        .sample_ready(rdy[0]), .sample_valid(sv[0]), .sample_data(sd0),
        .total_sample_count(tot[0]), .underrun_count(und[0])
    );

    sample_unpacker #(.WORD_W(16), .SAMPLE_W(4), .MSB_FIRST(1'b1), .COUNT_W(32)) dut1 (
        .clk_sample(clk), .reset_n(reset_n), .clear(clear),
        .packet_empty(empty[1]), .packet_data(pdata[1]), .packet_read(prd[1]),
        .sample_ready(rdy[1]), .sample_valid(sv[1]), .sample_data(sd1),
        .total_sample_count(tot[1]), .underrun_count(und[1])
    );

    sample_unpacker #(.WORD_W(16), .SAMPLE_W(16), .MSB_FIRST(1'b1), .COUNT_W(32)) dut2 (
        .clk_sample(clk), .reset_n(reset_n), .clear(clear),
        .packet_empty(empty[2]), .packet_data(pdata[2]), .packet_read(prd[2]),
        .sample_ready(rdy[2]), .sample_valid(sv[2]), .sample_data(sd2),
        .total_sample_count(tot[2]), .underrun_count(und[2])
    );

    for (genvar k = 0; k < 3; k++) begin : g_fifo
        assign empty[k] = (rd[k] == wr[k]);
        assign pdata[k] = mem[k][rd[k]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Show-ahead FIFO models pop on the DUT read strobe.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (prd[k]) rd[k] <= rd[k] + 5'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nbad++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, req);
        end
    endtask

    task automatic push(input int k, input logic [15:0] w);
        mem[k][wr[k]] = w;
        wr[k] = wr[k] + 5'd1;
    endtask

    task automatic want(input int k, input logic [15:0] v);
        case (k)
            0: exp0.push_back(v);
            1: exp1.push_back(v);
            default: exp2.push_back(v);
        endcase
    endtask

    task automatic take(input int k, input logic [15:0] act);
        logic [15:0] e;
        bit have;
        have = 1'b0;
        e = '0;
        case (k)
            0: if (exp0.size() > 0) begin have = 1'b1; e = exp0.pop_front(); end
            1: if (exp1.size() > 0) begin have = 1'b1; e = exp1.pop_front(); end
            default: if (exp2.size() > 0) begin have = 1'b1; e = exp2.pop_front(); end
        endcase
        nvec++;
        if (!have) begin
            nbad++;
            $display("FAIL sample%0d: got unexpected %0h, wanted none", k, act);
        end else if (act !== e) begin
            nbad++;
            $display("FAIL sample%0d: got %0h, wanted %0h", k, act, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: score accepted samples, hold stability, read gating and valid runs.
    always @(negedge clk) begin
        if (sv[0] && rdy[0]) take(0, 16'(sd0));
        if (sv[1] && rdy[1]) take(1, 16'(sd1));
        if (sv[2] && rdy[2]) take(2, sd2);
        if (prev_stall && sv[0]) check("hold_data", 32'(sd0), 32'(prev_data));
        if (prd[0]) check("read_gate", 32'(dut0.lvl_after < 3), 32'd1);
        prev_stall = sv[0] && !rdy[0];
        prev_data = sd0;
        run0 = sv[0] ? run0 + 1 : 0;
        if (run0 > maxrun) maxrun = run0;
    end

    initial begin
        reset_n = 1'b0;
        clear = 1'b0;
        rdy = 3'b111;
        push(0, 16'hFAC6);
        push(1, 16'hA5C3);
        push(1, 16'h1234);
        push(2, 16'hA5C3);
        push(2, 16'h1234);
        tick(2);
        check("rst_valid", 32'(sv), 32'd0);
        check("rst_read", 32'(prd), 32'd0);
        check("rst_data", 32'(sd0), 32'd0);
        check("rst_total", tot[0], 32'd0);
        check("rst_under", und[0], 32'd0);

        want(0, 16'd6); want(0, 16'd0); want(0, 16'd3);
        want(0, 16'd5); want(0, 16'd7);
        want(1, 16'hA); want(1, 16'h5); want(1, 16'hC); want(1, 16'h3);
        want(1, 16'h1); want(1, 16'h2); want(1, 16'h3); want(1, 16'h4);
        want(2, 16'hA5C3); want(2, 16'h1234);
        reset_n = 1'b1;
        tick(15);
        check("resid_valid", 32'(sv[0]), 32'd0);
        check("resid_lvl", 32'(dut0.lvl), 32'd1);
        check("resid_read", 32'(prd[0]), 32'd0);
        check("a_total0", tot[0], 32'd5);
        check("a_total1", tot[1], 32'd8);
        check("a_total2", tot[2], 32'd2);

        push(0, 16'h1234);
        push(0, 16'hBEEF);
        want(0, 16'd1); want(0, 16'd5); want(0, 16'd1); want(0, 16'd2);
        want(0, 16'd2); want(0, 16'd4); want(0, 16'd7); want(0, 16'd6);
        want(0, 16'd5); want(0, 16'd7); want(0, 16'd5);
        tick(20);
        check("a2_total", tot[0], 32'd16);
        check("a2_lvl", 32'(dut0.lvl), 32'd0);

        for (int pass = 0; pass < 2; pass++) begin
            reset_n = 1'b0;
            tick(1);
            reset_n = 1'b1;
            check("pulse_total", tot[0], 32'd0);
            push(0, 16'hFAC6);
            push(0, 16'h1234);
            push(0, 16'hBEEF);
            want(0, 16'd6); want(0, 16'd0); want(0, 16'd3); want(0, 16'd5);
            want(0, 16'd7); want(0, 16'd1); want(0, 16'd5); want(0, 16'd1);
            want(0, 16'd2); want(0, 16'd2); want(0, 16'd4); want(0, 16'd7);
            want(0, 16'd6); want(0, 16'd5); want(0, 16'd7); want(0, 16'd5);
            maxrun = 0;
            if (pass == 0) begin
                tick(25);
                check("burst_run", 32'(maxrun), 32'd16);
            end else begin
                tick(5);
                rdy[0] = 1'b0;
                tick(5);
                rdy[0] = 1'b1;
                tick(25);
            end
            check("burst_total", tot[0], 32'd16);
            check("burst_lvl", 32'(dut0.lvl), 32'd0);
        end

        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(2);
        check("idle_under", und[0], 32'd0);
        push(0, 16'hFAC6);
        want(0, 16'd6); want(0, 16'd0); want(0, 16'd3); want(0, 16'd5);
        want(0, 16'd7); want(0, 16'd1); want(0, 16'd5);
        tick(10);
        push(0, 16'h1234);
        tick(3);
        check("underrun", und[0], 32'd5);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_valid", 32'(sv[0]), 32'd0);
        check("clr_data", 32'(sd0), 32'd0);
        check("clr_lvl", 32'(dut0.lvl), 32'd0);
        check("clr_total", tot[0], 32'd7);

        push(0, 16'hFAC6);
        want(0, 16'd6); want(0, 16'd0); want(0, 16'd3);
        want(0, 16'd5); want(0, 16'd7);
        tick(15);
        check("post_clr_total", tot[0], 32'd12);

        push(0, 16'hBEEF);
        want(0, 16'd7);
        tick(3);
        reset_n = 1'b0;
        #1;
        check("async_valid", 32'(sv[0]), 32'd0);
        check("async_data", 32'(sd0), 32'd0);
        check("async_total", tot[0], 32'd0);
        check("async_under", und[0], 32'd0);
        check("async_read", 32'(prd[0]), 32'd0);
        tick(2);
        reset_n = 1'b1;
        push(0, 16'h1234);
        want(0, 16'd4); want(0, 16'd6); want(0, 16'd0);
        want(0, 16'd1); want(0, 16'd1);
        tick(15);
        check("realign_total", tot[0], 32'd5);

        check("left0", 32'(exp0.size()), 32'd0);
        check("left1", 32'(exp1.size()), 32'd0);
        check("left2", 32'(exp2.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
